// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel receiver with 2-entry output buffer
// Rebuilds LSB-first WIDTH-bit words framed by frame_sync; flags short frames and overruns.
module deserializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_data,
  input  logic             frame_sync,
  input  logic             clear_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             sync_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic push_req;
  logic full;
  logic pop;
  logic do_push;
  logic drop;

  assign word     = {serial_data, sr[WIDTH-1:1]};
  assign push_req = sync_d && (cnt == LAST);
  assign full     = (count == 2'd2);
  assign pop      = out_valid && out_ready;
  // A pop frees a slot at the same edge, so a full buffer can still take the word.
  assign do_push  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d    <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
    end else begin
      sync_d    <= frame_sync;
      frame_err <= 1'b0;
      if (sync_d) begin
        sr  <= word;
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end else if (cnt != '0) begin
        cnt       <= '0;
        frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // Set has priority over clear so a coincident overrun is never lost.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed scoreboard bench for deserializer
module tb_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial_data;
  logic        frame_sync;
  logic        clear_err;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  deserializer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_data(serial_data),
    .frame_sync (frame_sync),
    .clear_err  (clear_err),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives frame_sync high for nbits cycles with data lagging by one cycle.
  // ready_at raises out_ready in that loop cycle; rst_at asserts reset there and aborts.
  task automatic send_bits(input logic [95:0] bits, input int nbits,
                           input int ready_at, input int rst_at);
    for (int i = 0; i <= nbits; i++) begin
      @(posedge clk); #1;
      if (i == rst_at) begin
        rst_n       = 1'b0;
        frame_sync  = 1'b0;
        serial_data = 1'b0;
        return;
      end
      if (i == ready_at) out_ready = 1'b1;
      frame_sync  = (i < nbits);
      serial_data = (i > 0) ? bits[i-1] : 1'b0;
    end
    @(posedge clk); #1;
    serial_data = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", out_data, 32'hxxxx_xxxx);
      end else begin
        check("scoreboard_word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    serial_data = 1'b0;
    frame_sync  = 1'b0;
    clear_err   = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;

    // Single frame, one-cycle valid at S+33
    out_ready = 1'b1;
    exp_q.push_back(32'hA5C3_1E7F);
    send_bits({64'h0, 32'hA5C3_1E7F}, 32, -1, -1);
    check("t1_valid",    32'(out_valid), 32'd1);
    check("t1_data",     out_data,       32'hA5C3_1E7F);
    @(posedge clk); #1;
    check("t1_valid_off", 32'(out_valid), 32'd0);

    // Three back-to-back words into a stalled buffer: third dropped
    out_ready = 1'b0;
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h8000_0000);
    send_bits({32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001}, 96, -1, -1);
    check("t2_overrun",  32'(overrun),   32'd1);
    check("t2_head",     out_data,       32'h0000_0001);
    repeat (3) @(posedge clk); #1;
    check("t2_stable",   out_data,       32'h0000_0001);
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("t2_drained",  32'(out_valid), 32'd0);
    check("t2_sticky",   32'(overrun),   32'd1);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    check("t2_cleared",  32'(overrun),   32'd0);

    // Short frame then a full frame
    send_bits({64'h0, 32'h0000_03A5}, 10, -1, -1);
    check("t3_err_early", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    check("t3_err_pulse", 32'(frame_err), 32'd1);
    @(posedge clk); #1;
    check("t3_err_off",   32'(frame_err), 32'd0);
    exp_q.push_back(32'h1234_5678);
    send_bits({64'h0, 32'h1234_5678}, 32, -1, -1);
    repeat (3) @(posedge clk); #1;
    check("t3_no_err",    32'(frame_err), 32'd0);

    // Full buffer, third word completes on the same edge as a pop
    out_ready = 1'b0;
    exp_q.push_back(32'hCAFE_BABE);
    exp_q.push_back(32'h0BAD_F00D);
    exp_q.push_back(32'h1357_9BDF);
    send_bits({32'h1357_9BDF, 32'h0BAD_F00D, 32'hCAFE_BABE}, 96, 96, -1);
    check("t4_no_overrun", 32'(overrun),   32'd0);
    repeat (3) @(posedge clk); #1;
    check("t4_drained",    32'(out_valid), 32'd0);

    // Reset at bit 20 with one word buffered
    out_ready = 1'b0;
    send_bits({64'h0, 32'h55AA_55AA}, 32, -1, -1);
    check("t5_buffered",   32'(out_valid), 32'd1);
    send_bits({64'h0, 32'h7777_7777}, 32, -1, 21);
    #1;
    check("t5_rst_valid",  32'(out_valid), 32'd0);
    check("t5_rst_ovr",    32'(overrun),   32'd0);
    check("t5_rst_ferr",   32'(frame_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("t5_no_ferr",    32'(frame_err), 32'd0);
    out_ready = 1'b1;
    exp_q.push_back(32'h0F1E_2D3C);
    send_bits({64'h0, 32'h0F1E_2D3C}, 32, -1, -1);
    check("t5_data",       out_data,       32'h0F1E_2D3C);
    repeat (3) @(posedge clk); #1;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
